// File: rtl/arb_pkg.sv
// Shared types for mem_arbiter: FSM states, requester ownership encoding
// and default bus widths.
package arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and data requesters. Fixed DM priority by
// default; round-robin on conflict when ARB_RR_EN is defined.
module arb_pick
    import arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  owner_t last,
    output owner_t owner
);

`ifdef ARB_RR_EN
    // On conflict the side that did not win last time goes first.
    always_comb begin
        owner = OWN_IF;
        if (if_req && dm_req)
            owner = (last == OWN_IF) ? OWN_DM : OWN_IF;
        else if (dm_req)
            owner = OWN_DM;
    end
`else
    logic unused_in;
    assign unused_in = (last == OWN_DM) ^ if_req;
    assign owner     = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one
// transaction outstanding. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wmask,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                stall,
    output logic                err
);

    state_t state;
    owner_t owner;
    owner_t pick;
    owner_t last;

    logic any_req;
    logic issue_ack;
    logic resp;
    logic load;

    assign any_req   = if_req | dm_req;
    assign issue_ack = (state == S_ISSUE) && mem_ready;
    assign resp      = (state == S_WAIT) && mem_rvalid;
    // A response cycle doubles as the next arbitration cycle.
    assign load      = any_req && ((state == S_IDLE) || resp);

    arb_pick u_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .last   (last),
        .owner  (pick)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= OWN_IF;
        else if (dm_gnt)
            last <= OWN_DM;
        else if (if_gnt)
            last <= OWN_IF;
    end
`else
    assign last = OWN_IF;
`endif

    assign if_gnt    = issue_ack && (owner == OWN_IF);
    assign dm_gnt    = issue_ack && (owner == OWN_DM);
    assign if_rvalid = resp && (owner == OWN_IF);
    assign dm_rvalid = resp && (owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    // Gated by reset so every output reads 0 while rst is low.
    assign stall     = rst & ((if_req & ~if_gnt) | (dm_req & ~dm_gnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= OWN_IF;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            // Responses outside WAIT are stray: flag and drop.
            if (mem_rvalid && (state != S_WAIT))
                err <= 1'b1;

            if (load) begin
                state     <= S_ISSUE;
                owner     <= pick;
                mem_req   <= 1'b1;
                mem_addr  <= (pick == OWN_DM) ? dm_addr : if_addr;
                mem_we    <= (pick == OWN_DM) && dm_we;
                mem_wdata <= (pick == OWN_DM) ? dm_wdata : '0;
                mem_wmask <= (pick == OWN_DM) ? dm_wmask : '0;
            end else if (issue_ack) begin
                state     <= S_WAIT;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end else if (resp) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences
// for reset, stray responses and back-to-back arbitration.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, dm_req, dm_we, mem_ready, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_wmask;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_req, mem_we, stall, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wmask(dm_wmask), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall), .err(err)
    );

    logic [6:0]   ctl;
    logic [132:0] dat;
    logic [139:0] outs;
    assign ctl  = {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, stall, err};
    assign dat  = {mem_we, mem_wmask, mem_addr, mem_wdata, if_rdata, dm_rdata};
    assign outs = {ctl, dat};

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [3:0]  dmask;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic [6:0]  ctl;   // {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, stall, err}
        logic        mwe;
        logic [3:0]  mmask;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    vec_t vt[11];
    logic [1:0]  exp_g[4];
    logic [31:0] exp_a;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic set_in(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                          input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                          input logic [3:0] dmask, input logic rdy, input logic rv,
                          input logic [31:0] rdata);
        if_req = ireq;  if_addr = iaddr;
        dm_req = dreq;  dm_we = dwe; dm_addr = daddr; dm_wdata = dwd; dm_wmask = dmask;
        mem_ready = rdy; mem_rvalid = rv; mem_rdata = rdata;
    endtask

    task automatic set_idle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // single IF read, then DM write vs IF conflict, then IF held 3 cycles in ISSUE
        vt[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                   7'b0000010, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                   7'b1100000, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h13,
                   7'b0001000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h13, 32'h0};
        vt[3]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,
                   7'b0000010, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[4]  = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,
                   7'b1010010, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0, 32'h0};
        vt[5]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h55,
                   7'b0000110, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h55};
        vt[6]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   7'b1000010, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 32'h0};
        vt[7]  = vt[6];
        vt[8]  = vt[6];
        vt[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                   7'b1100000, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 32'h0};
        vt[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE0001,
                   7'b0001000, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE0001, 32'h0};

`ifdef ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};   // {if, dm}: DM, IF, DM, IF
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};   // DM always wins
`endif

        set_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 chk("reset_outputs", 160'(outs), 160'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_in(vt[i].ireq, vt[i].iaddr, vt[i].dreq, vt[i].dwe, vt[i].daddr,
                   vt[i].dwd, vt[i].dmask, vt[i].rdy, vt[i].rv, vt[i].rdata);
            #2;
            chk($sformatf("vec%0d_ctl", i), 160'(ctl), 160'(vt[i].ctl));
            chk($sformatf("vec%0d_data", i), 160'(dat),
                160'({vt[i].mwe, vt[i].mmask, vt[i].maddr, vt[i].mwd, vt[i].ird, vt[i].drd}));
        end

        // reset while WAIT, then a stray response after release
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #2 chk("rst_seq_dm_gnt", 160'(ctl), 160'(7'b1010000));
        @(negedge clk);
        set_in(1'b1, 32'h44, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b1, 32'h99);
        rst = 1'b0;
        #2 chk("rst_in_wait_outputs", 160'(outs), 160'd0);
        @(negedge clk);
        #2 chk("rst_held_outputs", 160'(outs), 160'd0);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        #2 chk("post_rst_idle", 160'(outs), 160'd0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h77);
        #2 chk("stray_not_forwarded", 160'({ctl, if_rdata, dm_rdata}), 160'd0);
        @(negedge clk);
        set_idle();
        #2 chk("stray_sets_err", 160'(err), 160'(1'b1));
        @(negedge clk);
        #2 chk("err_sticky", 160'(err), 160'(1'b1));

        // mem_ready and mem_rvalid together in ISSUE
        @(negedge clk);
        rst = 1'b0;
        #2 chk("err_cleared_by_reset", 160'(err), 160'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_in(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h5);
        #2 chk("ready_with_rvalid", 160'(ctl), 160'(7'b1100000));
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h7);
        #2 chk("resp_after_overlap_ctl", 160'(ctl), 160'(7'b0001001));
        chk("resp_after_overlap_rdata", 160'(if_rdata), 160'(32'h7));

        // both requesters asserting continuously
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_in(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_a = (exp_g[k] == 2'b01) ? 32'h100 : 32'h200;
            @(negedge clk);
            set_in(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
            #2;
            chk($sformatf("cont%0d_gnt", k), 160'({if_gnt, dm_gnt}), 160'(exp_g[k]));
            chk($sformatf("cont%0d_addr", k), 160'(mem_addr), 160'(exp_a));
            @(negedge clk);
            set_in(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 32'(k));
            #2;
            chk($sformatf("cont%0d_rvalid", k), 160'({if_rvalid, dm_rvalid}), 160'(exp_g[k]));
        end
        @(negedge clk);
        set_idle();
        #2 chk("cont_no_err", 160'(err), 160'(1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; write mask width is DATA_W/8.
REQ-003 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock, rising edge; reset is asynchronous and active-low.
REQ-004 SHALL have fetch-side ports: if_req (in, 1, fetch request), if_addr (in, ADDR_W), if_gnt (out, 1), if_rvalid (out, 1), if_rdata (out, DATA_W).
REQ-005 SHALL have data-side ports: dm_req (in, 1), dm_we (in, 1, write), dm_addr (in, ADDR_W), dm_wdata (in, DATA_W), dm_wmask (in, DATA_W/8), dm_gnt (out, 1), dm_rvalid (out, 1), dm_rdata (out, DATA_W).
REQ-006 SHALL have memory-side ports: mem_req, mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_wmask (out, DATA_W/8), mem_ready (in, 1), mem_rvalid (in, 1), mem_rdata (in, DATA_W).
REQ-007 SHALL have status outputs: stall (out, 1, core must hold) and err (out, 1, sticky protocol error).

Function
REQ-008 SHALL share one single-port memory between fetch (IF) and data (DM) requesters; at most one transaction outstanding.
REQ-009 SHALL implement FSM IDLE, ISSUE, WAIT; IDLE -> ISSUE when any req high; ISSUE -> WAIT on mem_ready; WAIT -> IDLE on mem_rvalid, or WAIT -> ISSUE on mem_rvalid if any req is high (back-to-back, no bubble).
REQ-010 SHALL on entering ISSUE register the winner (owner) and its we/addr/wdata/wmask; IF transactions drive mem_we=0 and mem_wmask=0.
REQ-011 SHALL hold mem_req=1 with stable fields for every ISSUE cycle until mem_ready=1.
REQ-012 SHALL pulse owner's gnt for exactly the one cycle where state=ISSUE and mem_ready=1; requesters hold req/fields stable until gnt.
REQ-013 SHALL assert owner's rvalid combinationally when state=WAIT and mem_rvalid=1, with rdata=mem_rdata; the non-owner's rvalid stays 0 and its rdata is 0.
REQ-014 SHALL treat writes identically to reads: memory returns mem_rvalid as write acknowledge, forwarded as dm_rvalid.
REQ-015 SHALL by default use fixed priority DM over IF when both requests are high in the arbitration cycle.
REQ-016 SHALL drive stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt).
REQ-017 SHALL set err=1 when mem_rvalid=1 in IDLE or ISSUE; err stays set until reset; the stray response is dropped.
REQ-018 SHALL ignore req deassertion before gnt (protocol violation, undefined result); simultaneous mem_ready and mem_rvalid in ISSUE: mem_rvalid ignored and err set.

Reset
REQ-019 SHALL on rst=0 asynchronously force state IDLE, owner=IF, last-winner=IF, err=0, and all outputs 0.
REQ-020 SHALL drop any in-flight transaction on reset mid-operation; a late mem_rvalid after release while in IDLE sets err.

Configuration
REQ-021 SHALL compile round-robin arbitration when ARB_RR_EN is defined: on conflict, grant the requester not granted last (last-winner updated on each grant); the first conflict after reset goes to DM.
REQ-022 SHALL without ARB_RR_EN use fixed DM priority; the last-winner register is absent.

Structure
REQ-023 SHALL place the FSM state enum, owner enum (OWN_IF, OWN_DM) and default widths in shared package arb_pkg.
REQ-024 SHALL isolate winner selection in sub-module arb_pick (inputs if_req, dm_req, last-winner; output owner).

Verification
REQ-025 SHALL verify: if_req=1 at addr 0x0000_0010, mem_ready=1, mem_rvalid=1 with 0x0000_0013 one cycle later -> mem_req cycle 1, if_gnt cycle 1, if_rvalid=1 with if_rdata=0x0000_0013 cycle 2.
REQ-026 SHALL verify: if_req and dm_req (write 0xDEADBEEF, mask 0xF) high in the same cycle, no macro -> DM granted first, IF issued in the cycle of the DM ack, stall high for IF throughout.
REQ-027 SHALL verify: with ARB_RR_EN and both requesters asserting continuously -> grants alternate DM, IF, DM, IF.
REQ-028 SHALL verify: mem_ready held 0 for 3 cycles in ISSUE -> mem_req/mem_addr stable, no gnt until the 4th cycle.
REQ-029 SHALL verify: rst=0 asserted in WAIT, then released, then stray mem_rvalid=1 -> all outputs 0 during reset, err=1 after the stray mem_rvalid.
